// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO. The result is computed on the start edge and
// parked in shadow registers. It is committed after a fixed busy window.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDU_Start,
    output logic        E_MDU_Busy,
    output logic [31:0] E_MDU_Out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   hi, hi_nx, lo, lo_nx;
    logic [31:0]   sh_hi, sh_hi_nx, sh_lo, sh_lo_nx;
    logic          dz, dz_nx;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [32:0] dvd_s, dvs_s;
    logic [31:0]        quo_s, rem_s, dvs_u, quo_u, rem_u;
    logic               div_zero;

    assign prod_s = 64'($signed(E_A)) * 64'($signed(E_B));
    assign prod_u = {32'b0, E_A} * {32'b0, E_B};

    // 33-bit signed divide keeps 0x80000000 / -1 representable; divisor forced to 1 on zero
    assign div_zero = (E_B == 32'd0);
    assign dvd_s    = {E_A[31], E_A};
    assign dvs_s    = div_zero ? 33'sd1 : {E_B[31], E_B};
    assign quo_s    = 32'(dvd_s / dvs_s);
    assign rem_s    = 32'(dvd_s % dvs_s);
    assign dvs_u    = div_zero ? 32'd1 : E_B;
    assign quo_u    = E_A / dvs_u;
    assign rem_u    = E_A % dvs_u;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            sh_hi <= sh_hi_nx;
            sh_lo <= sh_lo_nx;
            dz    <= dz_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_nx    = hi;
        lo_nx    = lo;
        sh_hi_nx = sh_hi;
        sh_lo_nx = sh_lo;
        dz_nx    = dz;
        case (state)
            IDLE: begin
                case (E_MDUOp)
                    OP_MULT, OP_MULTU: begin
                        {sh_hi_nx, sh_lo_nx} = (E_MDUOp == OP_MULT) ? prod_s : prod_u;
                        dz_nx    = 1'b0;
                        cnt_nx   = CW'(MULT_CYCLES);
                        state_nx = RUN;
                    end
                    OP_DIV: begin
                        sh_lo_nx = quo_s;
                        sh_hi_nx = rem_s;
                        dz_nx    = div_zero;
                        cnt_nx   = CW'(DIV_CYCLES);
                        state_nx = RUN;
                    end
                    OP_DIVU: begin
                        sh_lo_nx = quo_u;
                        sh_hi_nx = rem_u;
                        dz_nx    = div_zero;
                        cnt_nx   = CW'(DIV_CYCLES);
                        state_nx = RUN;
                    end
                    OP_MTHI: hi_nx = E_A;
                    OP_MTLO: lo_nx = E_A;
                    default: ;
                endcase
            end
            RUN: begin
                // ops arriving while busy are dropped; only the countdown advances
                if (cnt == CW'(1)) begin
                    if (!dz) begin
                        hi_nx = sh_hi;
                        lo_nx = sh_lo;
                    end
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign E_MDU_Start = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    assign E_MDU_Busy  = (state == RUN);
    assign E_MDU_Out   = (E_MDUOp == OP_MFHI) ? hi :
                         (E_MDUOp == OP_MFLO) ? lo : 32'd0;
    assign E_HI        = hi;
    assign E_LO        = lo;
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: a table of directed ops, hand-written reset/ignore sequences, and random
// ops. Each cycle is compared against an arithmetic reference model.
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] mout, hi, lo;

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_MDUOp(op), .E_A(a), .E_B(b),
        .E_MDU_Start(start), .E_MDU_Busy(busy), .E_MDU_Out(mout),
        .E_HI(hi), .E_LO(lo)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, a pending result, and the absolute cycle at which it lands
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        p_skip = 1'b0;
    longint      cyc = 0, done = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rh, output logic [31:0] rl, output logic skip);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        skip = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            4'd1: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            4'd2: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
            4'd3: if (y == 0) skip = 1'b1;
                  else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            4'd4: if (y == 0) skip = 1'b1;
                  else begin rl = x / y; rh = x % y; end
            default: ;
        endcase
    endtask

    task automatic model_edge(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic was_busy, sk;
        logic [31:0] rh, rl;
        was_busy = (cyc < done);
        cyc++;
        if (reset) begin
            if (was_busy) begin
                if (cyc == done && !p_skip) begin m_hi = p_hi; m_lo = p_lo; end
            end else if (o >= 4'd1 && o <= 4'd4) begin
                model_calc(o, x, y, rh, rl, sk);
                p_hi = rh; p_lo = rl; p_skip = sk;
                done = cyc + ((o <= 4'd2) ? MC : DC);
            end else if (o == 4'd7) m_hi = x;
            else if (o == 4'd8) m_lo = x;
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; done = 0;
    endtask

    // one cycle: check combinational outputs before the edge, registered state after it
    task automatic apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y;
        #1;
        chk("start", 32'(start), 32'(o >= 4'd1 && o <= 4'd4));
        chk("out", mout, (o == 4'd5) ? m_hi : ((o == 4'd6) ? m_lo : 32'd0));
        @(posedge clk);
        model_edge(o, x, y);
        #1;
        op = 4'd0;
        chk("busy", 32'(busy), 32'(cyc < done));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          ncyc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        tbl[4] = '{4'd7, 32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0};
        tbl[5] = '{4'd8, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
        tbl[6] = '{4'd4, 32'd9,        32'd0,        32'h00001234, 32'h00005678, DC};
        tbl[7] = '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       DC};

        // power-on reset
        reset = 1'b0; op = 4'd5; a = '0; b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mfhi", mout, 32'd0);
        apply(4'd0, 0, 0);
        reset = 1'b1;

        // reset mid-stream after HI/LO hold data
        apply(4'd7, 32'hAAAA0001, 0);
        apply(4'd8, 32'hBBBB0002, 0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst2_hi", hi, 32'd0);
        chk("rst2_lo", lo, 32'd0);
        repeat (3) apply(4'd5, 0, 0);
        reset = 1'b1;
        apply(4'd6, 0, 0);
        op = 4'd6; #1;
        chk("rst2_mflo", mout, 32'd0);

        // directed table
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].op, tbl[i].a, tbl[i].b);
            n = 0;
            while (busy && n < 100) begin
                n++;
                apply(4'd0, 0, 0);
            end
            chk($sformatf("tbl%0d_cycles", i), 32'(n), 32'(tbl[i].ncyc));
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            op = 4'd6; #1;
            chk($sformatf("tbl%0d_mflo", i), mout, tbl[i].lo);
            op = 4'd5; #1;
            chk($sformatf("tbl%0d_mfhi", i), mout, tbl[i].hi);
            op = 4'd0;
        end

        // MFLO during busy returns the old LO
        apply(4'd1, 32'd6, 32'd7);
        op = 4'd6; #1;
        chk("mflo_busy_old", mout, 32'd14);
        n = 0;
        while (busy && n < 100) begin n++; apply(4'd6, 0, 0); end
        chk("mult67_cycles", 32'(n), 32'(MC));
        chk("mult67_lo", lo, 32'd42);

        // divide by zero with a MULT injected in busy cycle 3
        apply(4'd4, 32'd9, 32'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            apply((n == 3) ? 4'd1 : 4'd0, 32'd6, 32'd7);
        end
        chk("dz_cycles", 32'(n), 32'(DC));
        chk("dz_hi", hi, 32'd0);
        chk("dz_lo", lo, 32'd42);
        apply(4'd0, 0, 0);
        chk("dz_idle_after", 32'(busy), 32'd0);

        // reset in busy cycle 2 aborts without commit
        apply(4'd1, 32'd6, 32'd7);
        apply(4'd0, 0, 0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (2) apply(4'd0, 0, 0);
        reset = 1'b1;
        repeat (6) apply(4'd0, 0, 0);
        chk("abort_no_commit", lo, 32'd0);
        apply(4'd1, 32'd6, 32'd7);
        n = 0;
        while (busy && n < 100) begin n++; apply(4'd0, 0, 0); end
        chk("fresh_cycles", 32'(n), 32'(MC));
        chk("fresh_lo", lo, 32'd42);

        // random ops, many landing while busy
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
            apply(ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit sitting beside the E-stage ALU.
- Consumes the forwarded E-stage operands (the same values that feed the ALU A/B inputs) plus a decoded MDU op.
- Owns the HI/LO registers and exposes busy/start status to the hazard controller, which stalls D-stage MDU instructions.
- Its read result is muxed into the E-stage AO path feeding the EM register.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start edge (>=1)
- DIV_CYCLES, 10, busy cycles after a div/divu start edge (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- E_MDUOp  input  4  op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE
- E_A  input  32  forwarded rs value
- E_B  input  32  forwarded rt value
- E_MDU_Start  output  1  combinational: E_MDUOp in {1,2,3,4}
- E_MDU_Busy  output  1  registered: high while an operation is counting down
- E_MDU_Out  output  32  combinational: HI if MFHI, LO if MFLO, else 0
- E_HI  output  32  current HI register
- E_LO  output  32  current LO register

Behaviour:
- Reset (reset==0, async):
  - HI=0, LO=0, busy=0, counter=0, shadow HI/LO=0; E_MDU_Out=0 for any non-MF op.
  - Reset mid-operation aborts it; no commit ever occurs.
- States: IDLE (busy=0), RUN (busy=1, counter 1..N).
- IDLE, edge with MULT/MULTU:
  - Compute the 64-bit product now (signed / unsigned).
  - shadow_hi = product[63:32], shadow_lo = product[31:0].
  - counter=MULT_CYCLES, busy=1.
- IDLE, edge with DIV/DIVU:
  - shadow_lo = quotient, shadow_hi = remainder; counter=DIV_CYCLES, busy=1.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divisor==0: the operation still runs for DIV_CYCLES with busy=1, but HI/LO are NOT updated at commit.
- RUN, each edge: counter decrements.
  - On the edge where counter==1: HI<=shadow_hi, LO<=shadow_lo (unless div-by-zero), busy<=0, counter<=0.
  - Busy is therefore high for exactly N cycles after the start edge.
  - MFHI/MFLO in the cycle after busy falls return the new values.
- MTHI/MTLO in IDLE: HI<=E_A or LO<=E_A at the edge; visible via E_MDU_Out the next cycle.
- MFHI/MFLO: purely combinational read of the architectural HI/LO (not the shadow), valid in the same cycle.
- Any MDU op (1-8) presented while busy==1 is ignored with no state change.
  - The hazard controller guarantees this never happens: D stalls when the D op is an MDU op and (E_MDU_Start | E_MDU_Busy).
  - The block is nevertheless required to be robust to it.
- Start on the same edge as the commit is impossible by construction, because busy is still 1 on that edge and the op is ignored.
- NONE/invalid op: no state change.
- No internal reset-synchroniser; the deassertion timing is owned by the top level.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-stream -> HI=LO=0, busy=0, E_MDU_Out=0 on MFHI; release, then MFLO -> 0.
- Signed mult: MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO during busy (forced) returns the old LO.
- Unsigned mult: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Signed div:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Div by zero plus ignore-while-busy:
  - MTHI 0x1234, MTLO 0x5678, then DIVU A=9, B=0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
  - MULT issued at busy cycle 3 -> ignored, busy still falls at cycle 10.
- Reset mid-run: MULT 6*7, assert reset at busy cycle 2 -> busy=0 immediately, LO stays 0 after release (no commit); a fresh MULT 6*7 -> LO=42 after 5 cycles.
